// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: reads 1- or 2-byte instructions from program memory,
// presents them to the execute stage and applies taken jumps. Optional macro: FETCH_SEQ_HALT_EN.
module fetch_seq (
    input  logic       clk,
    input  logic       rst_n,
`ifdef FETCH_SEQ_HALT_EN
    input  logic       halt,
    output logic       halted,
`endif
    output logic [8:0] mem_addr,
    output logic       mem_rd,
    input  logic [7:0] mem_rdata,
    input  logic       mem_valid,
    output logic [7:0] opcode,
    output logic [7:0] operand,
    output logic       instr_valid,
    input  logic       instr_ack,
    input  logic       jump_operation,
    input  logic       jump_condition,
    output logic [8:0] pc,
    output logic [1:0] dbg_state
);

    // Handshakes: a memory read completes on a cycle with mem_rd=1 and mem_valid=1
    // (mem_addr is held until then); an instruction retires on a cycle with
    // instr_valid=1 and instr_ack=1. Either strobe is ignored without its partner.

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        DECODE    = 2'd2,
        EXEC      = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       run_q;
    logic       hold;
    logic       rd_take;
    logic       ack_take;
    logic       jump_take;
    logic [8:0] pc_q;
    logic [7:0] opcode_q;
    logic [7:0] operand_q;

    // run_q keeps mem_rd low during reset and rises on the first edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

`ifdef FETCH_SEQ_HALT_EN
    logic halted_q;

    // halt is looked at only when FETCH_OP is entered (reset exit or retirement).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (!run_q || ack_take) begin
            halted_q <= halt;
        end else if (halted_q && !halt) begin
            halted_q <= 1'b0;
        end
    end

    assign hold   = halted_q;
    assign halted = halted_q;
`else
    assign hold = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_OP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_OP: begin
                if (rd_take) begin
                    state_d = mem_rdata[7] ? FETCH_ARG : DECODE;
                end
            end
            FETCH_ARG: begin
                if (rd_take) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = EXEC;
            end
            EXEC: begin
                if (instr_ack) begin
                    state_d = FETCH_OP;
                end
            end
            default: begin
                state_d = FETCH_OP;
            end
        endcase
    end

    // Output logic
    always_comb begin
        mem_rd      = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            FETCH_OP:  mem_rd = run_q && !hold;
            FETCH_ARG: mem_rd = run_q;
            EXEC:      instr_valid = 1'b1;
            default: begin
                mem_rd      = 1'b0;
                instr_valid = 1'b0;
            end
        endcase
    end

    assign rd_take   = mem_rd && mem_valid;
    assign ack_take  = (state_q == EXEC) && instr_ack;
    assign jump_take = ack_take && jump_operation && jump_condition;

    // pc wraps modulo 512 through the 9-bit add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= 9'h000;
            opcode_q  <= 8'h00;
            operand_q <= 8'h00;
        end else begin
            if (rd_take) begin
                pc_q <= pc_q + 9'd1;
                if (state_q == FETCH_OP) begin
                    opcode_q <= mem_rdata;
                    if (!mem_rdata[7]) begin
                        operand_q <= 8'h00;
                    end
                end else begin
                    operand_q <= mem_rdata;
                end
            end else if (jump_take) begin
                pc_q <= {opcode_q[0], operand_q};
            end
        end
    end

    assign pc        = pc_q;
    assign mem_addr  = pc_q;
    assign opcode    = opcode_q;
    assign operand   = operand_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: bench-owned program memory, instruction-level reference model,
// directed jump/wrap/reset cases and a randomized program run.
module tb_fetch_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_valid = 1'b0;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic       instr_valid;
  logic       instr_ack = 1'b0;
  logic       jump_operation = 1'b0;
  logic       jump_condition = 1'b0;
  logic [8:0] pc;
  logic [1:0] dbg_state;
`ifdef FETCH_SEQ_HALT_EN
  logic       halt = 1'b0;
  logic       halted;
`endif

  fetch_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef FETCH_SEQ_HALT_EN
    .halt           (halt),
    .halted         (halted),
`endif
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_rdata      (mem_rdata),
    .mem_valid      (mem_valid),
    .opcode         (opcode),
    .operand        (operand),
    .instr_valid    (instr_valid),
    .instr_ack      (instr_ack),
    .jump_operation (jump_operation),
    .jump_condition (jump_condition),
    .pc             (pc),
    .dbg_state      (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference state
  logic [7:0] mem [512];
  logic [8:0] model_pc;
  logic [8:0] exp_q[$];
  int         n_total = 0;
  int         n_bad = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction-level model: which bytes are fetched, what is presented, where pc goes next.
  // Bench decoder: opcodes 0xA0..0xBF are conditional jumps to {op[0], arg}.
  task automatic model_instr(input logic cond, output logic [7:0] op, output logic [7:0] arg,
                             output logic two, output logic [8:0] next_pc);
    logic [8:0] p;
    p  = model_pc;
    op = mem[p];
    exp_q.push_back(p);
    p   = p + 9'd1;
    two = op[7];
    arg = 8'h00;
    if (two) begin
      arg = mem[p];
      exp_q.push_back(p);
      p = p + 9'd1;
    end
    if (op[7:5] == 3'b101 && cond) p = {op[0], arg};
    next_pc = p;
  endtask

  task automatic fetch_byte(input int wt);
    logic [8:0] a;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 16'd1, 16'd0);
      a = model_pc;
    end else begin
      a = exp_q.pop_front();
    end
    for (int i = 0; i < wt; i++) begin
      check_eq("wait_rd", 16'(mem_rd), 16'd1);
      check_eq("wait_addr", 16'(mem_addr), 16'(a));
      mem_valid = 1'b0;
      mem_rdata = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    check_eq("fetch_rd", 16'(mem_rd), 16'd1);
    check_eq("fetch_addr", 16'(mem_addr), 16'(a));
    mem_valid = 1'b1;
    mem_rdata = mem[a];
    @(negedge clk);
    mem_valid = 1'b0;
    mem_rdata = 8'($urandom_range(0, 255));
  endtask

  // driver: one full instruction starting at a negedge in FETCH_OP
  task automatic run_instr(input int w_op, input int w_arg, input int ack_d, input logic cond);
    logic [7:0]  op;
    logic [7:0]  arg;
    logic        two;
    logic [8:0]  npc;
    logic [8:0]  seq_pc;
    int unsigned t0;
    int          exp_cyc;
    t0 = cyc;
    model_instr(cond, op, arg, two, npc);
    fetch_byte(w_op);
    if (two) fetch_byte(w_arg);
    seq_pc = model_pc + (two ? 9'd2 : 9'd1);
    check_eq("dec_valid", 16'(instr_valid), 16'd0);
    check_eq("dec_rd", 16'(mem_rd), 16'd0);
    check_eq("dec_opcode", 16'(opcode), 16'(op));
    check_eq("dec_operand", 16'(operand), 16'(arg));
    check_eq("dec_pc", 16'(pc), 16'(seq_pc));
    jump_operation = (op[7:5] == 3'b101);
    jump_condition = cond;
    mem_valid      = 1'($urandom_range(0, 1));
    @(negedge clk);
    for (int d = 0; d < ack_d; d++) begin
      check_eq("exec_valid", 16'(instr_valid), 16'd1);
      check_eq("exec_rd", 16'(mem_rd), 16'd0);
      check_eq("exec_pc", 16'(pc), 16'(seq_pc));
      instr_ack = 1'b0;
      mem_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check_eq("exec_valid", 16'(instr_valid), 16'd1);
    check_eq("exec_opcode", 16'(opcode), 16'(op));
    instr_ack = 1'b1;
    @(negedge clk);
    instr_ack      = 1'b0;
    mem_valid      = 1'b0;
    jump_operation = 1'b0;
    jump_condition = 1'b0;
    exp_cyc = 3 + w_op + ack_d + (two ? 1 + w_arg : 0);
    check_eq("period", 16'(cyc - t0), 16'(exp_cyc));
    model_pc = npc;
    check_eq("next_pc", 16'(pc), 16'(model_pc));
    check_eq("retired_valid", 16'(instr_valid), 16'd0);
  endtask

  // reset pulse with a stray mem_valid that must be discarded
  task automatic do_reset();
    rst_n     = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 8'hFF;
    #1;
    check_eq("rst_rd", 16'(mem_rd), 16'd0);
    check_eq("rst_pc", 16'(pc), 16'h000);
    check_eq("rst_addr", 16'(mem_addr), 16'h000);
    check_eq("rst_opcode", 16'(opcode), 16'h00);
    check_eq("rst_operand", 16'(operand), 16'h00);
    check_eq("rst_valid", 16'(instr_valid), 16'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_hold_rd", 16'(mem_rd), 16'd0);
    check_eq("rst_hold_pc", 16'(pc), 16'h000);
    rst_n     = 1'b1;
    mem_valid = 1'b0;
    #1;
    check_eq("rel_rd_early", 16'(mem_rd), 16'd0);
    @(negedge clk);
    check_eq("rel_rd", 16'(mem_rd), 16'd1);
    check_eq("rel_addr", 16'(mem_addr), 16'h000);
    model_pc = 9'h000;
    exp_q.delete();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
  endtask

  initial begin
    clear_mem();
    model_pc = 9'h000;
    @(negedge clk);

    // NOP stream: addresses 0,1,2 at 3-cycle spacing, operand 0
    do_reset();
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 1'b0);
    check_eq("nop_pc", 16'(pc), 16'h003);

    // taken jump 0xA3 0x40 -> 0x140
    clear_mem();
    mem[0] = 8'hA3;
    mem[1] = 8'h40;
    do_reset();
    run_instr(0, 0, 0, 1'b1);
    check_eq("jump_taken_pc", 16'(pc), 16'h140);
    run_instr(0, 0, 0, 1'b0);

    // untaken jump 0xA4 -> sequential pc 0x002
    clear_mem();
    mem[0] = 8'hA4;
    mem[1] = 8'h55;
    do_reset();
    run_instr(0, 0, 1, 1'b0);
    check_eq("jump_not_taken_pc", 16'(pc), 16'h002);

    // pc wrap: jump to 0x1FF, 1-byte op there, next fetch at 0x000
    clear_mem();
    mem[0]      = 8'hA1;
    mem[1]      = 8'hFF;
    mem[9'h1FF] = 8'h05;
    do_reset();
    run_instr(0, 0, 0, 1'b1);
    check_eq("wrap_pre_pc", 16'(pc), 16'h1FF);
    run_instr(0, 0, 0, 1'b0);
    check_eq("wrap_pc", 16'(pc), 16'h000);
    run_instr(0, 0, 0, 1'b1);

    // slow memory, then reset in the middle of a pending read
    clear_mem();
    mem[1] = 8'h81;
    mem[2] = 8'h22;
    do_reset();
    run_instr(5, 0, 0, 1'b0);
    run_instr(5, 5, 2, 1'b0);
    check_eq("slow_pc", 16'(pc), 16'h003);
    for (int i = 0; i < 3; i++) begin
      check_eq("pend_rd", 16'(mem_rd), 16'd1);
      check_eq("pend_addr", 16'(mem_addr), 16'h003);
      @(negedge clk);
    end
    do_reset();
    run_instr(0, 0, 0, 1'b0);
    check_eq("restart_pc", 16'(pc), 16'h001);

`ifdef FETCH_SEQ_HALT_EN
    // halt raised mid-instruction: instruction completes, then fetch is held
    halt = 1'b1;
    run_instr(0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_eq("halted", 16'(halted), 16'd1);
      check_eq("halted_rd", 16'(mem_rd), 16'd0);
      check_eq("halted_pc", 16'(pc), 16'(model_pc));
      mem_valid = 1'b1;
      @(negedge clk);
    end
    mem_valid = 1'b0;
    halt      = 1'b0;
    @(negedge clk);
    check_eq("resume_halted", 16'(halted), 16'd0);
    run_instr(0, 0, 0, 1'b0);
`endif

    // randomized program
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
    do_reset();
    for (int n = 0; n < 150; n++) begin
      run_instr(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // watchdog: every wait above is a fixed cycle count, this only guards against a runaway bench
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
